// File: rtl/riscv_pkg.sv
// Shared types and constants for the CSR port arbiter.
package riscv_pkg;

   localparam int CSR_AW           = 12;
   localparam int CSR_MAX_WAIT_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      DBG_RD,
      DBG_WR,
      DBG_ACK
   } csr_arb_state_t;

endpackage

// File: rtl/riscv_csr_arb.sv
// Arbitrates the state-unit CSR port between the EX stage and the debug unit.
// EX is a combinational pass-through; debug runs read, optional write, ack.
module riscv_csr_arb
   import riscv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = CSR_MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              ex_csr_req,
   input  logic [11:0]       ex_csr_reg,
   input  logic              ex_csr_we,
   input  logic [XLEN-1:0]   ex_csr_wval,
   output logic [XLEN-1:0]   ex_csr_rval,
   output logic              ex_csr_stall,
   input  logic              dbg_csr_req,
   input  logic              dbg_csr_we,
   input  logic [11:0]       dbg_csr_reg,
   input  logic [XLEN-1:0]   dbg_csr_wdata,
   output logic              dbg_csr_ack,
   output logic [XLEN-1:0]   dbg_csr_rdata,
   output logic [11:0]       st_csr_reg,
   output logic              st_csr_we,
   output logic [XLEN-1:0]   st_csr_wval,
   input  logic [XLEN-1:0]   st_csr_rval
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   csr_arb_state_t      state_q, state_d;
   logic                cool_q, cool_d;
   logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
   logic [CSR_AW-1:0]   lreg_q, lreg_d;
   logic                lwe_q, lwe_d;
   logic [XLEN-1:0]     lwdata_q, lwdata_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                at_max;
   logic                accept;
   logic                forced;
   logic                st_we_raw;

   assign at_max = (wait_cnt_q == WW'(MAX_WAIT));

   always_comb begin
      state_d      = state_q;
      cool_d       = cool_q;
      wait_cnt_d   = wait_cnt_q;
      lreg_d       = lreg_q;
      lwe_d        = lwe_q;
      lwdata_d     = lwdata_q;
      rdata_d      = rdata_q;
      ack_d        = 1'b0;
      accept       = 1'b0;
      forced       = 1'b0;
      st_csr_reg   = lreg_q;
      st_csr_wval  = lwdata_q;
      st_we_raw    = 1'b0;
      ex_csr_stall = ex_csr_req;
      ex_csr_rval  = st_csr_rval;

      unique case (state_q)
         IDLE: begin
            accept       = dbg_csr_req & ~cool_q & (~ex_csr_req | at_max);
            // A starvation-forced accept steals this cycle from EX.
            forced       = accept & ex_csr_req;
            st_csr_reg   = ex_csr_reg;
            st_csr_wval  = ex_csr_wval;
            st_we_raw    = ex_csr_req & ex_csr_we & ~forced;
            ex_csr_stall = forced;
            cool_d       = 1'b0;
            if (accept) begin
               lreg_d     = dbg_csr_reg;
               lwe_d      = dbg_csr_we;
               lwdata_d   = dbg_csr_wdata;
               wait_cnt_d = '0;
               state_d    = DBG_RD;
            end else if (!dbg_csr_req) begin
               wait_cnt_d = '0;
            end else if (ex_csr_req && !cool_q && !at_max) begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         DBG_RD: begin
            rdata_d = st_csr_rval;
            state_d = lwe_q ? DBG_WR : DBG_ACK;
            ack_d   = ~lwe_q;
         end
         DBG_WR: begin
            st_we_raw = 1'b1;
            state_d   = DBG_ACK;
            ack_d     = 1'b1;
         end
         DBG_ACK: begin
            state_d = IDLE;
            cool_d  = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign st_csr_we     = st_we_raw & rstn;
   assign dbg_csr_ack   = ack_q;
   assign dbg_csr_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cool_q     <= 1'b0;
         wait_cnt_q <= '0;
         lreg_q     <= '0;
         lwe_q      <= 1'b0;
         lwdata_q   <= '0;
         rdata_q    <= '0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cool_q     <= cool_d;
         wait_cnt_q <= wait_cnt_d;
         lreg_q     <= lreg_d;
         lwe_q      <= lwe_d;
         lwdata_q   <= lwdata_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
      end
   end

endmodule

// File: tb/tb_riscv_csr_arb.sv
// Bench for riscv_csr_arb: directed scenarios plus random traffic
// against a transaction-queue reference model and a CSR memory.
module tb_riscv_csr_arb;

   localparam int XLEN = 32;
   localparam int MAXW = 8;

   logic            clk = 1'b0;
   logic            rstn;
   logic            ex_csr_req;
   logic [11:0]     ex_csr_reg;
   logic            ex_csr_we;
   logic [31:0]     ex_csr_wval;
   logic [31:0]     ex_csr_rval;
   logic            ex_csr_stall;
   logic            dbg_csr_req;
   logic            dbg_csr_we;
   logic [11:0]     dbg_csr_reg;
   logic [31:0]     dbg_csr_wdata;
   logic            dbg_csr_ack;
   logic [31:0]     dbg_csr_rdata;
   logic [11:0]     st_csr_reg;
   logic            st_csr_we;
   logic [31:0]     st_csr_wval;
   logic [31:0]     st_csr_rval;

   logic [31:0]     mem [0:4095];

   assign st_csr_rval = mem[st_csr_reg];

   always #5 clk = ~clk;

   riscv_csr_arb #(.XLEN(XLEN), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rstn(rstn),
      .ex_csr_req(ex_csr_req), .ex_csr_reg(ex_csr_reg),
      .ex_csr_we(ex_csr_we), .ex_csr_wval(ex_csr_wval),
      .ex_csr_rval(ex_csr_rval), .ex_csr_stall(ex_csr_stall),
      .dbg_csr_req(dbg_csr_req), .dbg_csr_we(dbg_csr_we),
      .dbg_csr_reg(dbg_csr_reg), .dbg_csr_wdata(dbg_csr_wdata),
      .dbg_csr_ack(dbg_csr_ack), .dbg_csr_rdata(dbg_csr_rdata),
      .st_csr_reg(st_csr_reg), .st_csr_we(st_csr_we),
      .st_csr_wval(st_csr_wval), .st_csr_rval(st_csr_rval)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: a pending debug op is a queue of phases
   // (1 = read, 2 = write, 3 = ack); empty queue means EX owns the port.
   int          ph[$];
   bit          m_cool;
   int          m_wait;
   logic [11:0] m_reg;
   logic [31:0] m_wd;
   logic [31:0] m_rd;
   logic        obs_stall;
   logic        obs_ack;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic        busy, acc, forced, e_we, we_s, cool_old;
      logic [11:0] e_reg, reg_s;
      logic [31:0] wval_s, rdv;
      int          p;
      #1;
      busy = (ph.size() > 0);
      p = busy ? ph[0] : 0;
      acc = 1'b0;
      forced = 1'b0;
      if (!busy) begin
         acc = dbg_csr_req && !m_cool && (!ex_csr_req || m_wait == MAXW);
         forced = acc && ex_csr_req;
         e_reg = ex_csr_reg;
         e_we = ex_csr_req && ex_csr_we && !forced;
         chk("st_wval_ex", st_csr_wval, ex_csr_wval);
         chk("stall_idle", 32'(ex_csr_stall), 32'(forced));
         chk("ack_idle", 32'(dbg_csr_ack), 32'd0);
      end else begin
         e_reg = m_reg;
         e_we = (p == 2);
         if (p == 2) chk("st_wval_dbg", st_csr_wval, m_wd);
         chk("stall_busy", 32'(ex_csr_stall), 32'(ex_csr_req));
         chk("ack_busy", 32'(dbg_csr_ack), 32'(p == 3));
      end
      if (!rstn) e_we = 1'b0;
      chk("st_reg", 32'(st_csr_reg), 32'(e_reg));
      chk("st_we", 32'(st_csr_we), 32'(e_we));
      chk("ex_rval", ex_csr_rval, mem[e_reg]);
      chk("dbg_rdata", dbg_csr_rdata, m_rd);
      obs_stall = ex_csr_stall;
      obs_ack = dbg_csr_ack;
      we_s = st_csr_we;
      reg_s = st_csr_reg;
      wval_s = st_csr_wval;
      rdv = mem[m_reg];
      @(posedge clk);
      if (we_s) mem[reg_s] = wval_s;
      cool_old = m_cool;
      if (!rstn) begin
         ph.delete();
         m_cool = 0;
         m_wait = 0;
         m_reg = '0;
         m_wd = '0;
         m_rd = '0;
      end else if (busy) begin
         if (p == 1) m_rd = rdv;
         if (p == 3) m_cool = 1;
         void'(ph.pop_front());
      end else begin
         m_cool = 0;
         if (acc) begin
            m_reg = dbg_csr_reg;
            m_wd = dbg_csr_wdata;
            m_wait = 0;
            ph.push_back(1);
            if (dbg_csr_we) ph.push_back(2);
            ph.push_back(3);
         end else if (!dbg_csr_req) begin
            m_wait = 0;
         end else if (ex_csr_req && !cool_old && m_wait < MAXW) begin
            m_wait++;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_ack(input int limit, output int n);
      bit got;
      got = 0;
      n = 0;
      while (!got && n < limit) begin
         n++;
         cyc();
         if (obs_ack) got = 1;
      end
      if (!got) n = -1;
   endtask

   task automatic dbg_go(logic [11:0] r, logic w, logic [31:0] d);
      dbg_csr_req = 1'b1;
      dbg_csr_reg = r;
      dbg_csr_we = w;
      dbg_csr_wdata = d;
   endtask

   initial begin
      int n;
      int heavy;
      logic [31:0] keep;
      for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E3779B1;
      mem[12'h341] = 32'h1234;
      mem[12'h305] = 32'h100;
      ph.delete();
      m_cool = 0; m_wait = 0; m_reg = '0; m_wd = '0; m_rd = '0;
      rstn = 1'b0;
      ex_csr_req = 0; ex_csr_reg = '0; ex_csr_we = 0; ex_csr_wval = '0;
      dbg_csr_req = 0; dbg_csr_reg = '0; dbg_csr_we = 0; dbg_csr_wdata = '0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      cyc();
      chk("reset_rdata", dbg_csr_rdata, 32'd0);
      rstn = 1'b1;

      ex_csr_req = 1; ex_csr_reg = 12'h300; ex_csr_we = 1; ex_csr_wval = 32'h8;
      cyc();
      chk("pt_mem", mem[12'h300], 32'h8);
      ex_csr_req = 0; ex_csr_we = 0;

      dbg_go(12'h341, 1'b0, 32'h0);
      wait_ack(10, n);
      dbg_csr_req = 0;
      chk("rd_latency", 32'(n), 32'd3);
      chk("rd_data", dbg_csr_rdata, 32'h1234);
      cyc();

      dbg_go(12'h305, 1'b1, 32'hDEAD0000);
      wait_ack(10, n);
      dbg_csr_req = 0;
      chk("wr_latency", 32'(n), 32'd4);
      chk("wr_old", dbg_csr_rdata, 32'h100);
      chk("wr_mem", mem[12'h305], 32'hDEAD0000);
      cyc();

      ex_csr_req = 1; ex_csr_reg = 12'h340; ex_csr_we = 1; ex_csr_wval = 32'h55;
      dbg_go(12'h341, 1'b0, 32'h0);
      n = 0;
      obs_stall = 0;
      while (!obs_stall && n < 20) begin
         n++;
         cyc();
      end
      chk("starve_cycles", 32'(n), 32'd9);
      wait_ack(10, n);
      dbg_csr_req = 0;
      chk("starve_ack", 32'(n), 32'd2);
      cyc();
      chk("starve_release", 32'(obs_stall), 32'd0);
      ex_csr_req = 0; ex_csr_we = 0;

      dbg_go(12'h341, 1'b0, 32'h0);
      wait_ack(10, n);
      chk("cool_first", 32'(n), 32'd3);
      wait_ack(10, n);
      dbg_csr_req = 0;
      chk("cool_second", 32'(n), 32'd4);
      cyc();

      keep = mem[12'h306];
      dbg_go(12'h306, 1'b1, 32'hCAFEF00D);
      cyc();
      rstn = 0;
      cyc();
      rstn = 1;
      dbg_csr_req = 0;
      repeat (4) cyc();
      chk("rst_abort_mem", mem[12'h306], keep);
      chk("rst_abort_rdata", dbg_csr_rdata, 32'd0);

      heavy = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) heavy = $urandom_range(0, 1);
         ex_csr_req = heavy != 0 ? ($urandom_range(0, 15) != 0)
                                 : 1'($urandom_range(0, 1));
         ex_csr_we = 1'($urandom_range(0, 1));
         ex_csr_reg = 12'h300 + 12'($urandom_range(0, 7));
         ex_csr_wval = $urandom;
         if (obs_ack && $urandom_range(0, 3) != 0) dbg_csr_req = 0;
         if (!dbg_csr_req && $urandom_range(0, 3) == 0)
            dbg_go(12'h300 + 12'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $urandom);
         rstn = ($urandom_range(0, 499) != 0);
         if (!rstn) dbg_csr_req = 0;
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_csr_arb.md
Name: riscv_csr_arb

Overview:
Arbitrates the single CSR read/write port of the state unit between the execute-stage ALU and the debug unit.
- The EX path is a zero-latency combinational pass-through, because the ALU consumes st_csr_rval in the same cycle it issues a request.
- Debug accesses are sequenced by an FSM: read, optional write, then ack.
- A starvation counter guarantees debug progress by stalling EX.
- Sits between riscv_alu (ex_csr_* outputs) and the CSR state block.

Parameters:
XLEN, 32, data width of CSR values.
MAX_WAIT, 8, maximum IDLE cycles a pending debug request waits behind EX CSR traffic before EX is stalled (must be ≥1).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
ex_csr_req  in  1  valid CSR instruction in EX (non-bubble)
ex_csr_reg  in  12  EX CSR address
ex_csr_we  in  1  EX write enable
ex_csr_wval  in  XLEN  EX write value
ex_csr_rval  out  XLEN  CSR read data to ALU
ex_csr_stall  out  1  stall EX; its CSR access is not performed this cycle
dbg_csr_req  in  1  debug request; held until ack
dbg_csr_we  in  1  debug write (sampled at accept)
dbg_csr_reg  in  12  debug CSR address (sampled at accept)
dbg_csr_wdata  in  XLEN  debug write data (sampled at accept)
dbg_csr_ack  out  1  one-cycle completion pulse
dbg_csr_rdata  out  XLEN  CSR value before the access; valid while ack=1, held afterwards
st_csr_reg  out  12  CSR address to state unit
st_csr_we  out  1  write strobe to state unit
st_csr_wval  out  XLEN  write value to state unit
st_csr_rval  in  XLEN  combinational read data from state unit

Behaviour:
- States: IDLE, DBG_RD, DBG_WR, DBG_ACK. Also a 1-bit cool flag, set on leaving DBG_ACK and cleared after one IDLE cycle.
- Reset (rstn=0 at posedge):
  - state=IDLE, cool=0, wait_cnt=0, latched dbg reg/we/wdata=0, dbg_csr_rdata=0, dbg_csr_ack=0.
  - Reset mid-transaction aborts it: no ack, and no write if reset lands in DBG_RD.
  - While rstn=0, st_csr_we is forced 0.
- IDLE (EX owns the port):
  - st_csr_reg=ex_csr_reg, st_csr_wval=ex_csr_wval, st_csr_we=ex_csr_req&ex_csr_we.
  - ex_csr_rval=st_csr_rval; ex_csr_stall=0.
- Accepting a debug request in IDLE:
  - Accept when dbg_csr_req=1, cool=0, and either ex_csr_req=0 or wait_cnt==MAX_WAIT.
  - On accept: latch reg/we/wdata, clear wait_cnt, go to DBG_RD.
  - In the accept cycle EX still owns the port, unless acceptance was forced by starvation. In that case ex_csr_stall=1 and st_csr_we=0 in that cycle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each IDLE cycle with dbg_csr_req&ex_csr_req&!cool.
  - Clears on accept, or when dbg_csr_req=0.
- DBG_RD:
  - st_csr_reg=latched reg, st_csr_we=0; capture dbg_csr_rdata<=st_csr_rval.
  - Next state is DBG_WR if latched we=1, else DBG_ACK.
- DBG_WR: st_csr_reg=latched reg, st_csr_we=1, st_csr_wval=latched wdata. Next state is DBG_ACK.
- DBG_ACK: dbg_csr_ack=1 (registered, exactly one cycle), st_csr_we=0. Next state is IDLE with cool=1.
- EX stall rule: in every non-IDLE state, ex_csr_stall=ex_csr_req, and ex_csr_rval=st_csr_rval (don't-care to EX because stalled).
- Debug latency, counted from the accept edge N:
  - read: ack at cycle N+2;
  - write: ack at N+3.
- Cool-down: the debug master drops req on the edge where it sees ack. Any req in the first IDLE cycle after ack is ignored, which guarantees EX at least one free cycle between debug accesses.
- Write-data rule: debug write data is written unmodified; no set/clear semantics.
- Illegal CSR addresses are not checked here; the state unit handles them.

Decomposition:
- riscv_pkg holds:
  - csr_arb_state_t enum (IDLE, DBG_RD, DBG_WR, DBG_ACK);
  - the CSR address width constant (12);
  - the default MAX_WAIT.
- No sub-module: FSM, counter and muxes stay in one file (about 150–200 lines).

Test Plan:
1. Pass-through: reset released; ex_csr_req=1, ex_csr_reg=0x300, we=1, wval=0x8 → st_csr_reg=0x300, st_csr_we=1 the same cycle; ex_csr_rval=st_csr_rval; ex_csr_stall=0.
2. Debug read with EX idle: dbg req reg=0x341, we=0, state holds 0x1234 → DBG_RD one cycle later, ack at accept+2 with rdata=0x1234, st_csr_we never asserted.
3. Debug write: reg=0x305, wdata=0xDEAD0000, old value 0x100 → st_csr_we=1 with wval=0xDEAD0000 at accept+2; ack at accept+3 with rdata=0x100.
4. Starvation: ex_csr_req held at 1 with MAX_WAIT=8, dbg req asserted → accept on the 9th IDLE cycle (wait_cnt==8), ex_csr_stall=1 from accept through DBG_ACK, then 0 in the next IDLE cycle.
5. Cool-down: master keeps req high after ack → no accept in the first IDLE cycle; accept in the following cycle (EX idle).
6. Reset mid-op: rstn=0 for one edge while in DBG_RD of a write → no st_csr_we pulse, no ack, all outputs at reset values, FSM in IDLE.
